// File: rtl/if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : if_stage                                                        |
// | Purpose  : MIPS instruction-fetch stage with PC and IF/ID pipeline register|
// | Options  : IF_PERF_CNT_EN adds perf_fetch / perf_bubble counters           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Jump,
  input  logic [31:0] ID_jpc,
  input  logic        Branch,
  input  logic [31:0] EX_bpc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ID_Inst,
  output logic [31:0] ID_PC,
  output logic [31:0] IF_PC
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_bubble
`endif
);

  logic [31:0] r_pc;
  logic [31:0] r_id_inst;
  logic [31:0] r_id_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic        w_redirect;
  logic        w_advance;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_redirect = Branch | Jump;
  assign w_advance  = ~w_redirect & ~Stall;

  // Branch from EX is older than the jump in ID, so it wins; targets are word aligned.
  assign w_target   = Branch ? {EX_bpc[31:2], 2'b00} : {ID_jpc[31:2], 2'b00};

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_pc      <= RESET_PC;
      r_id_inst <= NOP_INST;
      r_id_pc   <= 32'd0;
    end else if (w_redirect) begin
      r_pc      <= w_target;
      r_id_inst <= NOP_INST;
      r_id_pc   <= 32'd0;
    end else if (w_advance) begin
      r_pc      <= w_pc_plus4;
      r_id_inst <= imem_data;
      r_id_pc   <= w_pc_plus4;
    end
  end

  assign imem_addr = r_pc;
  assign IF_PC     = r_pc;
  assign ID_Inst   = r_id_inst;
  assign ID_PC     = r_id_pc;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_bubble;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_perf_fetch  <= 32'd0;
      r_perf_bubble <= 32'd0;
    end else if (w_advance) begin
      r_perf_fetch  <= r_perf_fetch + 32'd1;
    end else begin
      r_perf_bubble <= r_perf_bubble + 32'd1;
    end
  end

  assign perf_fetch  = r_perf_fetch;
  assign perf_bubble = r_perf_bubble;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_if_stage                                                     |
// | Purpose  : directed + random bench for if_stage against a reference model  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        Stall = 1'b0;
  logic        Jump = 1'b0;
  logic [31:0] ID_jpc = 32'd0;
  logic        Branch = 1'b0;
  logic [31:0] EX_bpc = 32'd0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] ID_Inst;
  logic [31:0] ID_PC;
  logic [31:0] IF_PC;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_bubble;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state: what the fetch stage should hold after each edge.
  logic [31:0] m_pc, m_inst, m_idpc, m_fetch, m_bubble;

  always #5 CLK = ~CLK;

  // Instruction memory: address-derived words, never zero so they differ from NOP.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) | 32'h1;
  endfunction

  assign imem_data = mem_word(imem_addr);

  if_stage dut (
    .CLK(CLK), .Reset(Reset), .Stall(Stall), .Jump(Jump), .ID_jpc(ID_jpc),
    .Branch(Branch), .EX_bpc(EX_bpc), .imem_addr(imem_addr), .imem_data(imem_data),
    .ID_Inst(ID_Inst), .ID_PC(ID_PC), .IF_PC(IF_PC)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch(perf_fetch), .perf_bubble(perf_bubble)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_inst = NOP; m_idpc = 32'd0; m_fetch = 32'd0; m_bubble = 32'd0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":IF_PC"}, IF_PC, m_pc);
    chk({tag, ":imem_addr"}, imem_addr, m_pc);
    chk({tag, ":ID_Inst"}, ID_Inst, m_inst);
    chk({tag, ":ID_PC"}, ID_PC, m_idpc);
`ifdef IF_PERF_CNT_EN
    chk({tag, ":perf_fetch"}, perf_fetch, m_fetch);
    chk({tag, ":perf_bubble"}, perf_bubble, m_bubble);
`endif
  endtask

  // One clock edge with the given controls; called just after an edge.
  task automatic step(input logic s, input logic j, input logic [31:0] jt,
                      input logic b, input logic [31:0] bt, input string tag);
    logic [31:0] np, ni, nid;
    Stall = s; Jump = j; ID_jpc = jt; Branch = b; EX_bpc = bt;
    np = m_pc; ni = m_inst; nid = m_idpc;
    if (b) begin
      np = bt & ~32'd3; ni = NOP; nid = 32'd0; m_bubble++;
    end else if (j) begin
      np = jt & ~32'd3; ni = NOP; nid = 32'd0; m_bubble++;
    end else if (s) begin
      m_bubble++;
    end else begin
      ni = mem_word(m_pc); np = m_pc + 32'd4; nid = np; m_fetch++;
    end
    @(posedge CLK);
    #1;
    m_pc = np; m_inst = ni; m_idpc = nid;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, tag);
  endtask

  initial begin
    model_reset();
    // Test 1: reset held three cycles, then sequential fetch.
    #1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check_all("reset_hold");
    end
    Reset = 1'b1;
    chk("t1_pc0", IF_PC, 32'h0);
    idle("t1_a"); chk("t1_pc4", IF_PC, 32'h4); chk("t1_idpc4", ID_PC, 32'h4);
    chk("t1_inst0", ID_Inst, mem_word(32'h0));
    idle("t1_b"); chk("t1_pc8", IF_PC, 32'h8); chk("t1_idpc8", ID_PC, 32'h8);
    idle("t1_c"); chk("t1_idpc12", ID_PC, 32'hC);
    idle("t1_d"); chk("t2_at10", IF_PC, 32'h10);

    // Test 2: two-cycle stall at 0x10.
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, "t2_s1");
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, "t2_s2");
    chk("t2_hold_pc", IF_PC, 32'h10); chk("t2_hold_idpc", ID_PC, 32'h10);
    idle("t2_rel"); chk("t2_resume", IF_PC, 32'h14);
    chk("t2_inst", ID_Inst, mem_word(32'h10));

    // Test 3: jump to misaligned 0x203 once PC reaches 0x20.
    for (int i = 0; i < 8 && m_pc != 32'h20; i++) idle("t3_walk");
    chk("t3_at20", IF_PC, 32'h20);
    step(1'b0, 1'b1, 32'h0000_0203, 1'b0, 32'd0, "t3_jump");
    chk("t3_pc200", IF_PC, 32'h200); chk("t3_nop", ID_Inst, NOP);
    idle("t3_after"); chk("t3_word200", ID_Inst, mem_word(32'h200));
    chk("t3_idpc", ID_PC, 32'h204);

    // Test 4: branch beats simultaneous jump and stall.
    step(1'b1, 1'b1, 32'h80, 1'b1, 32'h40, "t4_all");
    chk("t4_pc40", IF_PC, 32'h40); chk("t4_nop", ID_Inst, NOP);

    // Test 5: PC wraps from 0xFFFF_FFFC.
    step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'd0, "t5_jump");
    chk("t5_top", IF_PC, 32'hFFFF_FFFC);
    idle("t5_wrap"); chk("t5_pc0", IF_PC, 32'h0); chk("t5_idpc0", ID_PC, 32'h0);
    chk("t5_inst", ID_Inst, mem_word(32'hFFFF_FFFC));

    // Randomised control traffic.
    for (int i = 0; i < 400; i++) begin
      logic s, j, b;
      s = ($urandom_range(0, 3) == 0);
      j = ($urandom_range(0, 7) == 0);
      b = ($urandom_range(0, 9) == 0);
      step(s, j, $urandom, b, $urandom, "rand");
    end

    // Test 6: asynchronous reset mid-stall at 0x30.
    step(1'b0, 1'b1, 32'h30, 1'b0, 32'd0, "t6_jump");
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, "t6_stall");
    chk("t6_at30", IF_PC, 32'h30);
    #2;
    Reset = 1'b0;
    #1;
    model_reset();
    check_all("t6_async");
    chk("t6_pc0", IF_PC, 32'h0);
    @(posedge CLK); #1;
    check_all("t6_held");
    Reset = 1'b1;
    idle("t6_rel"); chk("t6_pc4", IF_PC, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
